// File: rtl/segment_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : segment_dispatcher
// Purpose  : Pops motion records from the record FIFO, drops NOPs, halts on
//            HALT, flags unknown opcodes and dispatches MOVEs over valid/ready.
//            Optional counters: define SEGMENT_DISPATCHER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module segment_dispatcher #(
  parameter  int WordSize       = 8,
  parameter  int RecordWords    = 16,
  localparam int RecordSizeBits = WordSize * RecordWords
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [RecordSizeBits-1:0] fifo_data,
  output logic                      fifo_read_en,
  output logic                      seg_valid,
  input  logic                      seg_ready,
  output logic [RecordSizeBits-1:0] seg_data,
  input  logic                      resume,
  output logic                      halted,
  output logic                      err_opcode,
  input  logic                      err_clear
`ifdef SEGMENT_DISPATCHER_STATS_EN
  ,
  output logic [31:0]               stat_moves,
  output logic [31:0]               stat_underruns
`endif
);

  localparam logic [WordSize-1:0] OP_NOP  = WordSize'(0);
  localparam logic [WordSize-1:0] OP_MOVE = WordSize'(1);
  localparam logic [WordSize-1:0] OP_HALT = WordSize'(2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [RecordSizeBits-1:0] seg_data_q, seg_data_d;
  logic                      err_q, err_d;
  logic                      set_err;
  logic [WordSize-1:0]       opcode;
  logic                      fetch_ok;
  logic                      handshake;

  assign opcode    = fifo_data[WordSize-1:0];
  assign fetch_ok  = enable && !fifo_empty;
  assign handshake = (state_q == S_HOLD) && seg_ready;

  always_comb begin
    state_d    = state_q;
    seg_data_d = seg_data_q;
    set_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The pop happens this cycle regardless of opcode; only MOVE is held.
        seg_data_d = fifo_data;
        case (opcode)
          OP_MOVE: state_d = S_HOLD;
          OP_HALT: state_d = S_HALTED;
          OP_NOP:  state_d = S_IDLE;
          default: begin
            state_d = S_IDLE;
            set_err = 1'b1;
          end
        endcase
      end
      S_HOLD: begin
        if (seg_ready) state_d = fetch_ok ? S_LOAD : S_IDLE;
      end
      S_HALTED: begin
        if (resume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_clear ? 1'b0 : (err_q | set_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      seg_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_data_q <= seg_data_d;
      err_q      <= err_d;
    end
  end

  // Handshake-facing outputs depend on registered state only.
  assign fifo_read_en = (state_q == S_LOAD);
  assign seg_valid    = (state_q == S_HOLD);
  assign halted       = (state_q == S_HALTED);
  assign seg_data     = seg_data_q;
  assign err_opcode   = err_q;

`ifdef SEGMENT_DISPATCHER_STATS_EN
  logic [31:0] moves_q, moves_d;
  logic [31:0] underruns_q, underruns_d;

  always_comb begin
    moves_d     = moves_q + (handshake ? 32'd1 : 32'd0);
    underruns_d = underruns_q +
                  ((state_q == S_IDLE && enable && fifo_empty) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moves_q     <= '0;
      underruns_q <= '0;
    end else begin
      moves_q     <= moves_d;
      underruns_q <= underruns_d;
    end
  end

  assign stat_moves     = moves_q;
  assign stat_underruns = underruns_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
`default_nettype wire

// File: tb/tb_segment_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_dispatcher
// Purpose  : Directed self-checking bench for segment_dispatcher with a
//            queue model of the record FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_dispatcher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         fifo_empty;
  logic [127:0] fifo_data;
  logic         fifo_read_en;
  logic         seg_valid;
  logic         seg_ready;
  logic [127:0] seg_data;
  logic         resume;
  logic         halted;
  logic         err_opcode;
  logic         err_clear;
`ifdef SEGMENT_DISPATCHER_STATS_EN
  logic [31:0]  stat_moves;
  logic [31:0]  stat_underruns;
`endif

  always #5 clk = ~clk;

  segment_dispatcher #(.WordSize(8), .RecordWords(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_read_en   (fifo_read_en),
    .seg_valid      (seg_valid),
    .seg_ready      (seg_ready),
    .seg_data       (seg_data),
    .resume         (resume),
    .halted         (halted),
    .err_opcode     (err_opcode),
    .err_clear      (err_clear)
`ifdef SEGMENT_DISPATCHER_STATS_EN
    ,
    .stat_moves     (stat_moves),
    .stat_underruns (stat_underruns)
`endif
  );

  logic [127:0] q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           rd_cnt = 0;
  int           hs_cnt = 0;
  int           hs_cyc[$];
  logic [127:0] last_hs_data = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_rec(input logic [7:0] op, input logic [7:0] base);
    logic [127:0] r;
    r = '0;
    r[7:0] = op;
    for (int i = 1; i < 16; i++) r[i*8 +: 8] = base + 8'(i - 1);
    return r;
  endfunction

  task automatic upd_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [127:0] r);
    q.push_back(r);
    upd_fifo();
  endtask

  // One clock: observe strobes before the edge, update the FIFO model after it.
  task automatic tick();
    logic rd;
    rd = fifo_read_en;
    if (seg_valid && seg_ready) begin
      hs_cnt++;
      last_hs_data = seg_data;
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      rd_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_when_empty: got read_en=1 required read_en=0");
      end else begin
        q.delete(0);
      end
      upd_fifo();
    end
  endtask

  task automatic wait_hs(input int target, input string tag);
    int n;
    n = 0;
    while (hs_cnt < target && n < 60) begin
      tick();
      n++;
    end
    check(tag, 128'(hs_cnt), 128'(target));
  endtask

  initial begin
    int rd0;
    int hs0;
    logic stable;
    logic [127:0] rec_a;
    logic [127:0] rec_c;

    rst_n     = 1'b0;
    enable    = 1'b0;
    seg_ready = 1'b0;
    resume    = 1'b0;
    err_clear = 1'b0;
    upd_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_en", fifo_read_en, 0);
    check("rst_seg_valid", seg_valid, 0);
    check("rst_seg_data", seg_data, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err_opcode, 0);
`ifdef SEGMENT_DISPATCHER_STATS_EN
    check("rst_stat_moves", stat_moves, 0);
    check("rst_stat_underruns", stat_underruns, 0);
`endif
    rst_n = 1'b1;
    tick();

`ifdef SEGMENT_DISPATCHER_STATS_EN
    enable = 1'b1;
    repeat (7) tick();
    check("stat_underruns_7", stat_underruns, 7);
    seg_ready = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) push(mk_rec(8'h01, 8'(8'hE0 + i)));
    wait_hs(hs0 + 5, "stat_five_hs");
    check("stat_moves_5", stat_moves, 5);
    check("stat_underruns_hold", stat_underruns, 7);
    repeat (3) tick();
`endif

    // Single MOVE: latency and one pop
    enable    = 1'b1;
    seg_ready = 1'b1;
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    push(mk_rec(8'h01, 8'h10));
    check("lat_n_read_en", fifo_read_en, 0);
    tick();
    check("lat_n1_read_en", fifo_read_en, 1);
    check("lat_n1_valid", seg_valid, 0);
    tick();
    check("lat_n2_read_en", fifo_read_en, 0);
    check("lat_n2_valid", seg_valid, 1);
    check("move_byte1", seg_data[15:8], 8'h10);
    check("move_data", seg_data, mk_rec(8'h01, 8'h10));
    tick();
    check("move_valid_drop", seg_valid, 0);
    repeat (5) tick();
    check("move_one_pop", 128'(rd_cnt - rd0), 1);
    check("move_one_hs", 128'(hs_cnt - hs0), 1);

    // Three MOVEs with downstream stalled
    seg_ready = 1'b0;
    rec_a = mk_rec(8'h01, 8'h20);
    rec_c = mk_rec(8'h01, 8'h40);
    push(rec_a);
    push(mk_rec(8'h01, 8'h30));
    push(rec_c);
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1 && (seg_data !== rec_a || seg_valid !== 1'b1)) stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    check("stall_one_pop", 128'(rd_cnt - rd0), 1);
    seg_ready = 1'b1;
    hs_cyc.delete();
    wait_hs(hs0 + 3, "three_hs");
    check("three_hs_count", 128'(hs_cyc.size()), 3);
    if (hs_cyc.size() >= 3) begin
      check("gap_0_1", 128'(hs_cyc[1] - hs_cyc[0]), 2);
      check("gap_1_2", 128'(hs_cyc[2] - hs_cyc[1]), 2);
    end
    check("three_last_data", last_hs_data, rec_c);
    tick();
    check("three_fifo_empty", fifo_empty, 1);

    // NOP / MOVE / unknown / MOVE
    hs0 = hs_cnt;
    push(mk_rec(8'h00, 8'h50));
    push(mk_rec(8'h01, 8'h60));
    push(mk_rec(8'h7F, 8'h70));
    push(mk_rec(8'h01, 8'h80));
    repeat (20) tick();
    check("mix_hs", 128'(hs_cnt - hs0), 2);
    check("mix_last_data", last_hs_data, mk_rec(8'h01, 8'h80));
    check("mix_err_set", err_opcode, 1);
    check("mix_fifo_empty", fifo_empty, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("err_cleared", err_opcode, 0);
    // Clear held while an unknown opcode is loaded: clear wins.
    err_clear = 1'b1;
    push(mk_rec(8'hC3, 8'h00));
    repeat (4) tick();
    err_clear = 1'b0;
    tick();
    check("err_clear_priority", err_opcode, 0);

    // HALT then MOVE
    push(mk_rec(8'h02, 8'h90));
    push(mk_rec(8'h01, 8'hA0));
    for (int i = 0; i < 10 && !halted; i++) tick();
    check("halt_entered", halted, 1);
    rd0 = rd_cnt;
    repeat (20) tick();
    check("halt_no_pop", 128'(rd_cnt - rd0), 0);
    check("halt_still", halted, 1);
    check("halt_fifo_kept", fifo_empty, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted_low", halted, 0);
    tick();
    check("resume_read_en", fifo_read_en, 1);
    tick();
    check("resume_valid", seg_valid, 1);
    check("resume_data", seg_data, mk_rec(8'h01, 8'hA0));
    tick();

    // Asynchronous reset while holding a record
    seg_ready = 1'b0;
    push(mk_rec(8'h01, 8'hB0));
    for (int i = 0; i < 10 && !seg_valid; i++) tick();
    check("areset_pre_valid", seg_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", seg_valid, 0);
    check("areset_data", seg_data, 0);
    check("areset_read_en", fifo_read_en, 0);
    tick();
    rst_n = 1'b1;
    seg_ready = 1'b1;
    hs0 = hs_cnt;
    push(mk_rec(8'h01, 8'hC0));
    wait_hs(hs0 + 1, "after_reset_hs");
    check("after_reset_data", last_hs_data, mk_rec(8'h01, 8'hC0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
